// File: rtl/enable_pkg.sv
// Shared definitions for the enable-combining blocks: count-width helper,
// accumulate mode and a reference population count.
package enable_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int POP_MAX_W = 64;

  function automatic int pc_width(input int n_ch);
    return $clog2(n_ch + 1);
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX_W; i++) c = c + 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/enable_popcount.sv
// Combinational population count of an N_CH-bit enable vector.
module enable_popcount
  import enable_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int PC_W = pc_width(N_CH)
) (
  input  logic [N_CH-1:0] en,
  output logic [PC_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_CH; i++) cnt = cnt + PC_W'(en[i]);
  end

endmodule

// File: rtl/enable_window_accum.sv
// Sums per-cycle enable popcounts over WINDOW accepted samples and publishes
// each window total with a one-cycle valid pulse and a sticky overflow flag.
module enable_window_accum
  import enable_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int ACC_W  = 16,
  parameter int WINDOW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en_in,
  input  logic             in_valid,
  input  logic             clear,
  input  logic             mode_sat,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  output logic             overflow
);

  localparam int PC_W = pc_width(N_CH);
  localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] v);
    return v[ACC_W] ? '1 : v[ACC_W-1:0];
  endfunction

  logic [PC_W-1:0]  pc_p0;
  logic [PC_W-1:0]  pc_p1;
  logic             vld_p1;
  logic [ACC_W-1:0] acc_p2;
  logic             ovf_p2;
  logic [WC_W-1:0]  wcnt;
  mode_e            mode;
  logic [ACC_W:0]   nxt;
  logic [ACC_W-1:0] post;
  logic             last;

  enable_popcount #(.N_CH(N_CH), .PC_W(PC_W)) u_pop (
    .en  (en_in),
    .cnt (pc_p0)
  );

  // ---- stage 1: registered popcount ----
  always_ff @(posedge clk) begin
    if (rst || clear) vld_p1 <= 1'b0;
    else              vld_p1 <= in_valid;
    if (clear)         pc_p1 <= '0;
    else if (in_valid) pc_p1 <= pc_p0;
  end

  // ---- stage 2: accumulate and window close ----
  assign nxt  = {1'b0, acc_p2} + {{(ACC_W + 1 - PC_W){1'b0}}, pc_p1};
  assign post = (mode == MODE_SAT) ? sat_acc(nxt) : nxt[ACC_W-1:0];
  assign last = (wcnt == WC_W'(WINDOW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p2    <= '0;
      ovf_p2    <= 1'b0;
      wcnt      <= '0;
      mode      <= mode_sat ? MODE_SAT : MODE_WRAP;
      sum_out   <= '0;
      overflow  <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (clear) begin
        acc_p2 <= '0;
        ovf_p2 <= 1'b0;
        wcnt   <= '0;
        mode   <= mode_sat ? MODE_SAT : MODE_WRAP;
      end else if (vld_p1) begin
        if (last) begin
          sum_out   <= post;
          overflow  <= ovf_p2 | nxt[ACC_W];
          sum_valid <= 1'b1;
          acc_p2    <= '0;
          ovf_p2    <= 1'b0;
          wcnt      <= '0;
          mode      <= mode_sat ? MODE_SAT : MODE_WRAP;
        end else begin
          acc_p2 <= post;
          ovf_p2 <= ovf_p2 | nxt[ACC_W];
          wcnt   <= wcnt + WC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_enable_window_accum.sv
// Scoreboard bench: three configurations (W=4/ACC16, W=4/ACC4, W=1/ACC16)
// driven with directed windows; a monitor pops expected totals on sum_valid.
module tb_enable_window_accum;

  typedef struct {
    logic [15:0] s;
    logic        o;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  en0, en1, en2;
  logic        v0, v1, v2, c0, c1, c2, m0, m1, m2;
  logic [15:0] s0, s2;
  logic [3:0]  s1;
  logic        sv0, sv1, sv2, o0, o1, o2;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t qa[$], qb[$], qc[$];

  always @(posedge clk) cyc <= cyc + 1;

  enable_window_accum #(.N_CH(8), .ACC_W(16), .WINDOW(4)) dut_a (
    .clk(clk), .rst(rst), .en_in(en0), .in_valid(v0), .clear(c0), .mode_sat(m0),
    .sum_out(s0), .sum_valid(sv0), .overflow(o0));

  enable_window_accum #(.N_CH(8), .ACC_W(4), .WINDOW(4)) dut_b (
    .clk(clk), .rst(rst), .en_in(en1), .in_valid(v1), .clear(c1), .mode_sat(m1),
    .sum_out(s1), .sum_valid(sv1), .overflow(o1));

  enable_window_accum #(.N_CH(8), .ACC_W(16), .WINDOW(1)) dut_c (
    .clk(clk), .rst(rst), .en_in(en2), .in_valid(v2), .clear(c2), .mode_sat(m2),
    .sum_out(s2), .sum_valid(sv2), .overflow(o2));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic pop_check(input int id, input logic [15:0] s, input logic o);
    exp_t x;
    bit   empty;
    case (id)
      0:       empty = (qa.size() == 0);
      1:       empty = (qb.size() == 0);
      default: empty = (qc.size() == 0);
    endcase
    if (empty) begin
      n_chk++;
      $display("FAIL unexpected_sum_valid dut%0d: got pulse at cycle %0d expected none", id, cyc);
    end else begin
      case (id)
        0:       x = qa.pop_front();
        1:       x = qb.pop_front();
        default: x = qc.pop_front();
      endcase
      chk($sformatf("sum_out dut%0d", id), int'(s), int'(x.s));
      chk($sformatf("overflow dut%0d", id), int'(o), int'(x.o));
      chk($sformatf("latency dut%0d", id), cyc, x.c);
    end
  endtask

  always @(negedge clk) begin
    if (sv0) pop_check(0, s0, o0);
    if (sv1) pop_check(1, {12'b0, s1}, o1);
    if (sv2) pop_check(2, s2, o2);
  end

  // One input cycle for one DUT; a closing sample queues its expected result.
  task automatic step(input int id, input logic [7:0] e, input logic v, input logic c,
                      input logic m, input bit close, input logic [15:0] es, input logic eo);
    exp_t x;
    case (id)
      0:       begin en0 = e; v0 = v; c0 = c; m0 = m; end
      1:       begin en1 = e; v1 = v; c1 = c; m1 = m; end
      default: begin en2 = e; v2 = v; c2 = c; m2 = m; end
    endcase
    if (close) begin
      x.s = es; x.o = eo; x.c = cyc + 2;
      case (id)
        0:       qa.push_back(x);
        1:       qb.push_back(x);
        default: qc.push_back(x);
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int id, input logic m, input int n);
    for (int i = 0; i < n; i++) step(id, 8'h00, 1'b0, 1'b0, m, 1'b0, 16'd0, 1'b0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en0 = '0; en1 = '0; en2 = '0;
    v0 = 0; v1 = 0; v2 = 0; c0 = 0; c1 = 0; c2 = 0;
    m0 = 0; m1 = 1; m2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset sum_out a", int'(s0), 0);
    chk("reset overflow a", int'(o0), 0);
    chk("reset sum_valid a", int'(sv0), 0);
    chk("reset sum_out b", int'(s1), 0);
    rst = 1'b0;

    // DUT A: four samples of 0x03 -> 8
    for (int i = 0; i < 4; i++) step(0, 8'h03, 1, 0, 0, i == 3, 16'd8, 1'b0);
    idle(0, 0, 3);
    // Alternating valid with 0xFF: four accepted samples -> 32
    for (int i = 0; i < 8; i++) step(0, 8'hFF, ~i[0], 0, 0, i == 6, 16'd32, 1'b0);
    idle(0, 0, 3);
    // Clear on the third sample discards the partial window
    step(0, 8'hFF, 1, 0, 0, 0, 16'd0, 1'b0);
    step(0, 8'hFF, 1, 0, 0, 0, 16'd0, 1'b0);
    step(0, 8'hFF, 1, 1, 0, 0, 16'd0, 1'b0);
    step(0, 8'h01, 1, 0, 0, 0, 16'd0, 1'b0);
    chk("hold after clear", int'(s0), 32);
    for (int i = 0; i < 3; i++) step(0, 8'h01, 1, 0, 0, i == 2, 16'd4, 1'b0);
    idle(0, 0, 3);
    chk("sum held after window", int'(s0), 4);
    // Reset mid-window loses the partial window
    step(0, 8'hFF, 1, 0, 0, 0, 16'd0, 1'b0);
    step(0, 8'hFF, 1, 0, 0, 0, 16'd0, 1'b0);
    rst = 1'b1;
    step(0, 8'h00, 0, 0, 0, 0, 16'd0, 1'b0);
    rst = 1'b0;
    chk("mid rst sum_out", int'(s0), 0);
    chk("mid rst overflow", int'(o0), 0);
    chk("mid rst sum_valid", int'(sv0), 0);
    for (int i = 0; i < 4; i++) step(0, 8'h07, 1, 0, 0, i == 3, 16'd12, 1'b0);
    idle(0, 0, 3);

    // DUT B (ACC_W=4): sat latched in reset, mid-window change ignored
    step(1, 8'hFF, 1, 0, 1, 0, 16'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1, 8'hFF, 1, 0, 0, i == 2, 16'd15, 1'b1);
    idle(1, 0, 3);
    // Wrap window: 32 mod 16 = 0 with overflow
    step(1, 8'hFF, 1, 0, 0, 0, 16'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1, 8'hFF, 1, 0, 1, i == 2, 16'd0, 1'b1);
    idle(1, 1, 3);
    // Sat window: 16 clamps to 15
    for (int i = 0; i < 4; i++) step(1, 8'h0F, 1, 0, 1, i == 3, 16'd15, 1'b1);
    idle(1, 1, 3);
    // Overflow flag does not carry into the next window
    for (int i = 0; i < 4; i++) step(1, 8'h01, 1, 0, 1, i == 3, 16'd4, 1'b0);
    idle(1, 1, 3);

    // DUT C (WINDOW=1): every sample closes a window
    for (int i = 0; i < 6; i++) begin
      case (i % 3)
        0:       step(2, 8'h00, 1, 0, 0, 1, 16'd0, 1'b0);
        1:       step(2, 8'h0F, 1, 0, 0, 1, 16'd4, 1'b0);
        default: step(2, 8'hFF, 1, 0, 0, 1, 16'd8, 1'b0);
      endcase
    end
    idle(2, 0, 4);

    chk("pending a", qa.size(), 0);
    chk("pending b", qb.size(), 0);
    chk("pending c", qc.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
